// File: rtl/uxn_fetch_unit.sv
// uxn_fetch_unit: prefetching instruction fetch stage in front of the uxn decode/execute core.
// Keeps up to MAX_OUTST in-order reads in flight and buffers returned bytes with their addresses.
module uxn_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0100,
  parameter int                MAX_OUTST  = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_byte,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_busy
);

  // state | meaning
  // IDLE  | first cycle out of reset, nothing issued
  // RUN   | issuing reads and delivering bytes
  // FLUSH | discarding responses that predate a redirect

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + MAX_OUTST + 1);
  localparam int TAG_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] MAXO_C   = OUT_W'(MAX_OUTST);
  localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [OUT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_byte [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [ADDR_W-1:0] tag_q     [MAX_OUTST];
  logic [TAG_W-1:0]  tag_wr_q, tag_rd_q;

  logic              fifo_empty;
  logic [SUM_W-1:0]  inflight_sum;
  logic              grant;
  logic              resp;
  logic              push;
  logic              pop;

  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TAG_W'(1);
  endfunction

  // Counting FIFO entries plus in-flight reads reserves a slot for every response.
  always_comb begin
    fifo_empty   = (cnt_q == '0);
    inflight_sum = SUM_W'(cnt_q) + SUM_W'(outst_q);
    mem_req      = (state_q != S_IDLE) && (inflight_sum < DEPTH_S) && (outst_q < MAXO_C);
    mem_addr     = fetch_pc_q;
    grant        = mem_req && mem_gnt;
    resp         = mem_rvalid && (outst_q != '0);
    push         = resp && (drop_q == '0) && !redirect_valid;
    instr_valid  = !fifo_empty && !redirect_valid && (state_q != S_FLUSH);
    pop          = instr_valid && instr_ready;
    instr_byte   = fifo_empty ? '0 : fifo_byte[rd_ptr_q];
    instr_pc     = fifo_empty ? '0 : fifo_pc[rd_ptr_q];
    fetch_busy   = (outst_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q + OUT_W'(grant) - OUT_W'(resp);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    if (resp && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_FLUSH: if (drop_d == '0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Every read still in flight after this cycle belongs to the abandoned stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = outst_d;
      cnt_d      = '0;
      state_d    = ((state_q == S_IDLE) || (outst_d == '0)) ? S_RUN : S_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_byte[i] <= '0;
        fifo_pc[i]   <= '0;
      end
      for (int i = 0; i < MAX_OUTST; i++) tag_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;

      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          fifo_byte[wr_ptr_q] <= mem_rdata;
          fifo_pc[wr_ptr_q]   <= tag_q[tag_rd_q];
          wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      // Tags track every granted read, dropped or not, so they stay aligned with responses.
      if (grant) begin
        tag_q[tag_wr_q] <= fetch_pc_q;
        tag_wr_q        <= tag_next(tag_wr_q);
      end
      if (resp) tag_rd_q <= tag_next(tag_rd_q);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (cnt_q == DEPTH_C)));

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_gnt && !redirect_valid) |=> (mem_req && $stable(mem_addr)));

  a_outst_bound: assert property (@(posedge clk) disable iff (rst)
    (outst_q <= MAXO_C) && (drop_q <= outst_q) && (inflight_sum <= DEPTH_S));

endmodule

// File: tb/tb_uxn_fetch_unit.sv
// Directed bench for uxn_fetch_unit with an in-order memory model (1-cycle response, optional hold).
module tb_uxn_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_byte;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        fetch_busy;

  logic        rsp_hold;
  logic        inj_rvalid;
  logic        mdl_rvalid;
  logic [7:0]  mdl_rdata;
  logic [15:0] pend_q[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rvalid = mdl_rvalid | inj_rvalid;
  assign mem_rdata  = inj_rvalid ? 8'hEE : mdl_rdata;

  uxn_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_byte     (instr_byte),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_busy     (fetch_busy)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0100: return 8'hA0;
      16'h0101: return 8'h12;
      16'h0102: return 8'h34;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Memory answers a granted read on the following cycle unless rsp_hold is set.
  always @(posedge clk) begin
    if (rst) begin
      pend_q.delete();
      mdl_rvalid <= 1'b0;
      mdl_rdata  <= 8'h00;
    end else begin
      if (mem_req && mem_gnt) pend_q.push_back(mem_addr);
      if (!rsp_hold && pend_q.size() > 0) begin
        mdl_rvalid <= 1'b1;
        mdl_rdata  <= mem_byte(pend_q.pop_front());
      end else begin
        mdl_rvalid <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next delivered byte, checks it, and lets it pop.
  task automatic get_byte(input string tag, input logic [15:0] exp_pc);
    int n;
    n = 0;
    while (instr_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, {16'b0, instr_pc}, {16'b0, exp_pc});
    chk({tag, "_byte"}, {24'b0, instr_byte}, {24'b0, mem_byte(exp_pc)});
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, mem_req},     32'd0);
    chk({tag, "_addr"},  {16'b0, mem_addr},    32'h0100);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_byte"},  {24'b0, instr_byte},  32'd0);
    chk({tag, "_pc"},    {16'b0, instr_pc},    32'd0);
    chk({tag, "_busy"},  {31'b0, fetch_busy},  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_gnt = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    rsp_hold = 1'b0; inj_rvalid = 1'b0;

    // Reset values and cycle-exact first delivery
    step(); step();
    chk_reset_outputs("rst0");
    rst = 1'b0;
    step();
    chk("lat_c1_valid", {31'b0, instr_valid}, 32'd0);
    chk("lat_c1_req",   {31'b0, mem_req},     32'd1);
    chk("lat_c1_addr",  {16'b0, mem_addr},    32'h0100);
    step();
    chk("lat_c2_valid", {31'b0, instr_valid}, 32'd0);
    chk("lat_c2_busy",  {31'b0, fetch_busy},  32'd1);
    step();
    chk("s1_b0_valid", {31'b0, instr_valid}, 32'd1);
    chk("s1_b0_pc",    {16'b0, instr_pc},    32'h0100);
    chk("s1_b0_byte",  {24'b0, instr_byte},  32'hA0);
    step();
    chk("s1_b1_valid", {31'b0, instr_valid}, 32'd1);
    chk("s1_b1_pc",    {16'b0, instr_pc},    32'h0101);
    chk("s1_b1_byte",  {24'b0, instr_byte},  32'h12);
    step();
    chk("s1_b2_valid", {31'b0, instr_valid}, 32'd1);
    chk("s1_b2_pc",    {16'b0, instr_pc},    32'h0102);
    chk("s1_b2_byte",  {24'b0, instr_byte},  32'h34);

    // Core stalled: FIFO fills to depth and fetching stops
    rst = 1'b1; instr_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    chk("full_req",   {31'b0, mem_req},     32'd0);
    chk("full_busy",  {31'b0, fetch_busy},  32'd0);
    chk("full_valid", {31'b0, instr_valid}, 32'd1);
    chk("full_pc",    {16'b0, instr_pc},    32'h0100);
    instr_ready = 1'b1;
    get_byte("full_d0", 16'h0100);
    get_byte("full_d1", 16'h0101);
    get_byte("full_d2", 16'h0102);
    get_byte("full_d3", 16'h0103);
    get_byte("full_d4", 16'h0104);

    // Redirect with two reads in flight: both responses must be dropped
    rsp_hold = 1'b1;
    repeat (4) step();
    chk("rd2_busy", {31'b0, fetch_busy}, 32'd1);
    chk("rd2_req",  {31'b0, mem_req},    32'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    #1;
    chk("rd2_valid_redir", {31'b0, instr_valid}, 32'd0);
    step();
    redirect_valid = 1'b0; rsp_hold = 1'b0;
    #1;
    chk("rd2_flush_valid", {31'b0, instr_valid}, 32'd0);
    get_byte("rd2_b0", 16'h0200);
    get_byte("rd2_b1", 16'h0201);
    get_byte("rd2_b2", 16'h0202);

    // Redirect near the top of the address space: PC wraps
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    get_byte("wrap_b0", 16'hFFFE);
    get_byte("wrap_b1", 16'hFFFF);
    get_byte("wrap_b2", 16'h0000);
    get_byte("wrap_b3", 16'h0001);

    // Grant withheld: request and address hold steady, then delivery resumes
    redirect_valid = 1'b1; redirect_pc = 16'h0300; mem_gnt = 1'b0;
    step();
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_req_%0d", i),  {31'b0, mem_req},  32'd1);
      chk($sformatf("stall_addr_%0d", i), {16'b0, mem_addr}, 32'h0300);
      step();
    end
    chk("stall_valid", {31'b0, instr_valid}, 32'd0);
    mem_gnt = 1'b1;
    get_byte("stall_b0", 16'h0300);
    get_byte("stall_b1", 16'h0301);
    get_byte("stall_b2", 16'h0302);
    get_byte("stall_b3", 16'h0303);

    // Reset with reads in flight, then a stray rvalid with nothing outstanding
    rsp_hold = 1'b1;
    repeat (4) step();
    chk("mrst_busy_pre", {31'b0, fetch_busy}, 32'd1);
    rst = 1'b1;
    step();
    chk_reset_outputs("mrst");
    rsp_hold = 1'b0; mem_gnt = 1'b0;
    rst = 1'b0;
    step(); step();
    chk("spur_req_pre", {31'b0, mem_req}, 32'd1);
    inj_rvalid = 1'b1;
    step();
    inj_rvalid = 1'b0;
    #1;
    chk("spur_busy",  {31'b0, fetch_busy},  32'd0);
    chk("spur_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("spur_valid2", {31'b0, instr_valid}, 32'd0);
    mem_gnt = 1'b1;
    get_byte("mrst_b0", 16'h0100);
    get_byte("mrst_b1", 16'h0101);
    get_byte("mrst_b2", 16'h0102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
